// File: rtl/ir_nec_decoder.sv
// ir_nec_decoder -- NEC-style pulse-width IR frame decoder.
//
// The raw receiver output is synchronised, sampled once per prescaler tick,
// and the width (in ticks) of every high pulse is classified as leader,
// '0' bit or '1' bit. A complete frame is accepted only if every odd byte is
// the bitwise inverse of the byte below it.
//
// Optional feature: define IR_REPEAT_EN to recognise repeat codes (a short
// pulse right after a leader, following an earlier valid frame).
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-high reset
//   ir_data        in   raw IR receiver output (asynchronous to clk)
//   ir_data_array  out  last verified frame (DATA_BITS)
//   valid          out  one-clk pulse, ir_data_array was updated
//   err            out  one-clk pulse, a frame was discarded
//   repeat_pulse   out  one-clk pulse, repeat code accepted (0 unless IR_REPEAT_EN)
module ir_nec_decoder #(
    parameter int DATA_BITS = 32,
    parameter int TICK_DIV  = 128,
    parameter int CNT_W     = 8,
    parameter int LEAD_MIN  = 19,
    parameter int ONE_MIN   = 18,
    parameter int ONE_MAX   = 23,
    parameter int ZERO_MIN  = 7,
    parameter int ZERO_MAX  = 15,
    parameter int TIMEOUT   = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ir_data,
    output logic [DATA_BITS-1:0] ir_data_array,
    output logic                 valid,
    output logic                 err,
    output logic                 repeat_pulse
);

    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam int NPAIR = DATA_BITS / 16;

    localparam logic [PW-1:0]    L_PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] L_SAT      = '1;
    localparam logic [CNT_W-1:0] L_LEAD     = CNT_W'(LEAD_MIN);
    localparam logic [CNT_W-1:0] L_ONE_MIN  = CNT_W'(ONE_MIN);
    localparam logic [CNT_W-1:0] L_ONE_MAX  = CNT_W'(ONE_MAX);
    localparam logic [CNT_W-1:0] L_ZERO_MIN = CNT_W'(ZERO_MIN);
    localparam logic [CNT_W-1:0] L_ZERO_MAX = CNT_W'(ZERO_MAX);
    localparam logic [CNT_W-1:0] L_TO_M1    = CNT_W'(TIMEOUT - 1);
    localparam logic [BCW-1:0]   L_NBITS    = BCW'(DATA_BITS);

    typedef enum logic [1:0] {S_IDLE, S_LEADER, S_COLLECT, S_VERIFY} state_t;

    state_t               r_state, w_state_next;
    logic                 r_sync1, r_sync2;
    logic [PW-1:0]        r_presc;
    logic [CNT_W-1:0]     r_width;
    logic [BCW-1:0]       r_bitcnt, w_bitcnt_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic [DATA_BITS-1:0] r_array, w_array_next;
    logic                 r_valid, w_valid_next;
    logic                 r_err, w_err_next;
    logic                 r_repeat, w_repeat_next;
    logic                 r_drop, w_drop_next;
    logic                 r_have_frame;

    logic                 w_tick, w_fall, w_timeout;
    logic                 w_is_one, w_is_zero, w_is_rep;
    logic [NPAIR-1:0]     w_pair_ok;
    logic                 w_frame_ok;

    // Two-flop synchroniser for the asynchronous receiver output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ir_data;
            r_sync2 <= r_sync1;
        end
    end

    // Prescaler: one tick every TICK_DIV clocks
    assign w_tick = (r_presc == L_PRE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + 1'b1;
    end

    // High-width counter; a low sample clears it, so a nonzero count seen
    // together with a low sample marks a falling edge carrying that width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_width <= '0;
        end else if (w_tick) begin
            if (r_sync2) begin
                if (r_width != L_SAT) r_width <= r_width + 1'b1;
            end else begin
                r_width <= '0;
            end
        end
    end

    assign w_fall    = w_tick && !r_sync2 && (r_width != '0);
    assign w_timeout = w_tick && r_sync2 && (r_width == L_TO_M1);
    assign w_is_one  = (r_width >= L_ONE_MIN)  && (r_width <= L_ONE_MAX);
    assign w_is_zero = (r_width >= L_ZERO_MIN) && (r_width <= L_ZERO_MAX);

`ifdef IR_REPEAT_EN
    localparam logic [CNT_W-1:0] L_REP_MAX = CNT_W'(ZERO_MAX / 2);
    assign w_is_rep = (r_width >= L_ZERO_MIN) && (r_width <= L_REP_MAX);
`else
    assign w_is_rep = 1'b0;
`endif

    // Each 16-bit group: upper byte must be the inverse of the lower byte
    genvar gi;
    generate
        for (gi = 0; gi < NPAIR; gi++) begin : g_pair
            assign w_pair_ok[gi] = (r_shift[16*gi+15 -: 8] == ~r_shift[16*gi+7 -: 8]);
        end
    endgenerate
    assign w_frame_ok = &w_pair_ok;

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_bitcnt_next = r_bitcnt;
        w_array_next  = r_array;
        w_valid_next  = 1'b0;
        w_err_next    = 1'b0;
        w_repeat_next = 1'b0;
        w_drop_next   = r_drop;

        if (w_fall && r_drop) begin
            // Tail of a pulse that already timed out: it must not look like a leader
            w_drop_next = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fall && (r_width >= L_LEAD)) w_state_next = S_LEADER;
                end
                S_LEADER: begin
                    if (w_fall) begin
                        w_state_next = S_IDLE;
                        if (w_is_rep) begin
                            if (r_have_frame) w_repeat_next = 1'b1;
                            else              w_err_next    = 1'b1;
                        end else if (w_is_one || w_is_zero) begin
                            w_shift_next  = {{(DATA_BITS-1){1'b0}}, w_is_one};
                            w_bitcnt_next = BCW'(1);
                            w_state_next  = S_COLLECT;
                        end else begin
                            w_err_next = 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_timeout) begin
                        w_err_next   = 1'b1;
                        w_drop_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (w_fall) begin
                        if (w_is_one || w_is_zero) begin
                            w_shift_next  = {r_shift[DATA_BITS-2:0], w_is_one};
                            w_bitcnt_next = r_bitcnt + 1'b1;
                            if (w_bitcnt_next == L_NBITS) w_state_next = S_VERIFY;
                        end else begin
                            w_err_next   = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end
                end
                S_VERIFY: begin
                    if (w_tick) begin
                        w_state_next = S_IDLE;
                        if (w_frame_ok) begin
                            w_array_next = r_shift;
                            w_valid_next = 1'b1;
                        end else begin
                            w_err_next = 1'b1;
                        end
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_array      <= '0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_repeat     <= 1'b0;
            r_drop       <= 1'b0;
            r_have_frame <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_bitcnt <= w_bitcnt_next;
            r_array  <= w_array_next;
            r_valid  <= w_valid_next;
            r_err    <= w_err_next;
            r_repeat <= w_repeat_next;
            r_drop   <= w_drop_next;
            if (w_valid_next) r_have_frame <= 1'b1;
        end
    end

    assign ir_data_array = r_array;
    assign valid         = r_valid;
    assign err           = r_err;
    assign repeat_pulse  = r_repeat;

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed bench for ir_nec_decoder: pulse trains are built in tick units
// (TICK_DIV shortened to keep run time low) and outputs are checked against
// hand-computed values.
module tb_ir_nec_decoder;

    localparam int TD = 4;
    localparam int DW = 32;
`ifdef IR_REPEAT_EN
    localparam int ZW_EDGE = 8;
`else
    localparam int ZW_EDGE = 7;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ir_data = 1'b0;
    logic [DW-1:0] ir_data_array;
    logic          valid, err, repeat_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_v = 0, cnt_e = 0, cnt_r = 0, cnt_both = 0;
    int v0, e0, r0;

    ir_nec_decoder #(.DATA_BITS(DW), .TICK_DIV(TD)) dut (
        .clk           (clk),
        .reset         (reset),
        .ir_data       (ir_data),
        .ir_data_array (ir_data_array),
        .valid         (valid),
        .err           (err),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) cnt_v++;
        if (err) cnt_e++;
        if (repeat_pulse) cnt_r++;
        if (valid && err) cnt_both++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n * TD) @(negedge clk);
    endtask

    task automatic pulse(input int h, input int l);
        ir_data = 1'b1;
        repeat (h * TD) @(negedge clk);
        ir_data = 1'b0;
        repeat (l * TD) @(negedge clk);
    endtask

    task automatic send_bits(input logic [DW-1:0] d, input int n, input int zw, input int ow);
        pulse(20, 2);
        for (int i = DW - 1; i > DW - 1 - n; i--) pulse(d[i] ? ow : zw, 2);
    endtask

    task automatic snap();
        v0 = cnt_v; e0 = cnt_e; r0 = cnt_r;
    endtask

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        check("rst_array", 64'(ir_data_array), 64'h0);
        check("rst_valid", 64'(valid), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_repeat", 64'(repeat_pulse), 64'h0);
        reset = 1'b0;
        idle(3);

        // Good frame
        snap();
        send_bits(32'h00FF40BF, 32, 10, 20); idle(4);
        check("f1_valid", 64'(cnt_v - v0), 64'd1);
        check("f1_err", 64'(cnt_e - e0), 64'd0);
        check("f1_array", 64'(ir_data_array), 64'h00FF40BF);

        // Bit 0 flipped: inverse check fails
        snap();
        send_bits(32'h00FF40BE, 32, 10, 20); idle(4);
        check("flip_err", 64'(cnt_e - e0), 64'd1);
        check("flip_valid", 64'(cnt_v - v0), 64'd0);
        check("flip_array", 64'(ir_data_array), 64'h00FF40BF);

        // Timeout after 10 bits with high held 45 ticks
        snap();
        send_bits(32'hA5A5A5A5, 10, 10, 20);
        ir_data = 1'b1;
        repeat (37 * TD) @(negedge clk);
        check("to_early", 64'(cnt_e - e0), 64'd0);
        repeat (5 * TD) @(negedge clk);
        check("to_at40", 64'(cnt_e - e0), 64'd1);
        repeat (3 * TD) @(negedge clk);
        ir_data = 1'b0;
        idle(4);
        check("to_single_err", 64'(cnt_e - e0), 64'd1);
        check("to_valid", 64'(cnt_v - v0), 64'd0);

        // Recovery frame using range edges 15 / 18
        snap();
        send_bits(32'h10EF807F, 32, 15, 18); idle(4);
        check("f2_valid", 64'(cnt_v - v0), 64'd1);
        check("f2_array", 64'(ir_data_array), 64'h10EF807F);

        // Width 17 inside a frame
        snap();
        send_bits(32'h00FF40BF, 5, 10, 20);
        pulse(17, 2); idle(4);
        check("w17_err", 64'(cnt_e - e0), 64'd1);
        check("w17_valid", 64'(cnt_v - v0), 64'd0);

        // Leader-length (30) width inside a frame
        snap();
        send_bits(32'h00FF40BF, 5, 10, 20);
        pulse(30, 2); idle(4);
        check("w30_err", 64'(cnt_e - e0), 64'd1);

        // Reset after 16 bits
        snap();
        send_bits(32'h00FF40BF, 16, 10, 20);
        reset = 1'b1;
        #1;
        check("mrst_array", 64'(ir_data_array), 64'h0);
        check("mrst_valid", 64'(valid), 64'h0);
        check("mrst_err", 64'(err), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        idle(4);
        check("mrst_no_err", 64'(cnt_e - e0), 64'd0);

`ifdef IR_REPEAT_EN
        // Repeat code with no prior valid frame since reset
        snap();
        pulse(20, 2); pulse(7, 2); idle(4);
        check("rep_none_err", 64'(cnt_e - e0), 64'd1);
        check("rep_none_rep", 64'(cnt_r - r0), 64'd0);
`endif

        // Full frame after reset, edge widths ZW_EDGE / 23
        snap();
        send_bits(32'h00FF40BF, 32, ZW_EDGE, 23); idle(4);
        check("f3_valid", 64'(cnt_v - v0), 64'd1);
        check("f3_array", 64'(ir_data_array), 64'h00FF40BF);

`ifdef IR_REPEAT_EN
        snap();
        pulse(20, 2); pulse(7, 2); idle(4);
        check("rep_pulse", 64'(cnt_r - r0), 64'd1);
        check("rep_err", 64'(cnt_e - e0), 64'd0);
        check("rep_array", 64'(ir_data_array), 64'h00FF40BF);
`else
        check("rep_never", 64'(cnt_r), 64'd0);
`endif
        check("valid_err_both", 64'(cnt_both), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
